bg_image_loader: RTL and testbench

- Write side of the background-picture path: accepts the byte stream of a background download (OVR file) from the HPS download interface.
- Packs bytes into 16-bit {A,B,G,R} nibble words, buffers them, and issues word writes to the SDRAM controller with a ready handshake.
- Back-pressures the download with dl_wait when the buffer fills.
- Raises image_valid once a complete, error-free image is in SDRAM, so the pixel fetcher may start reading.

---
 rtl/bg_image_loader.sv | 196 +++++++++++++++++++
 tb/tb_bg_image_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_image_loader.sv
// Background-image loader: packs the download byte stream into 16-bit words,
// buffers them in a small FIFO and writes them to SDRAM with a ready handshake.
// image_valid rises once a complete, error-free image has been written.
module bg_image_loader #(
  parameter int ADDR_W     = 25,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BYTES  = 777600
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              image_valid,
  output logic [ADDR_W-1:0] byte_count,
  output logic              error
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [ADDR_W-1:0] MAX_CNT  = ADDR_W'(MAX_BYTES);
  localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_TWO    = ADDR_W'(2);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]    DEPTH_C  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]    WAIT_LVL = (PTR_W+1)'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic              act_q;
  logic              act_rise, act_fall;

  logic [ADDR_W-1:0] exp_q;
  logic [ADDR_W-1:0] bc_q;
  logic              err_q;
  logic [7:0]        low_q;
  logic              valid_q;
  logic              pad_q;

  logic              start_dl, byte_hit, byte_bad, enter_flush, pad_push, set_done;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [15:0]       fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, rd_next;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              push, pop;
  logic [ADDR_W-1:0] push_addr;
  logic [15:0]       push_data;

  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [15:0]       mem_din_q;
  logic              dl_wait_q;

  assign act_rise = dl_active & ~act_q;
  assign act_fall = ~dl_active & act_q;

  // Delayed copy of dl_active for edge detection
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) act_q <= 1'b0;
    else          act_q <= dl_active;
  end

  // FSM state register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (act_rise) state_d = S_LOAD;
      S_LOAD:         if (act_fall) state_d = S_FLUSH;
      S_FLUSH:        if (!pad_q && (cnt_q == '0) && !mem_we_q) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // FSM outputs: per-cycle control strobes for the datapath
  always_comb begin
    start_dl    = ((state_q == S_IDLE) || (state_q == S_DONE)) && act_rise;
    byte_hit    = (state_q == S_LOAD) && dl_wr && (dl_addr == exp_q) && (bc_q < MAX_CNT);
    byte_bad    = (state_q == S_LOAD) && dl_wr && !byte_hit;
    enter_flush = (state_q == S_LOAD) && act_fall;
    pad_push    = (state_q == S_FLUSH) && pad_q && (cnt_q != DEPTH_C);
    set_done    = (state_q == S_FLUSH) && (state_d == S_DONE);
  end

  assign push      = (byte_hit && dl_addr[0]) || pad_push;
  assign push_addr = pad_push ? {exp_q[ADDR_W-1:1], 1'b0} : {dl_addr[ADDR_W-1:1], 1'b0};
  assign push_data = pad_push ? {8'h00, low_q} : {dl_data, low_q};
  assign pop       = mem_we_q && mem_ready;
  assign rd_next   = rd_ptr_q + PTR_ONE;

  // Download bookkeeping: expected address, byte count, error and validity
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      exp_q   <= '0;
      bc_q    <= '0;
      err_q   <= 1'b0;
      low_q   <= '0;
      valid_q <= 1'b0;
      pad_q   <= 1'b0;
    end else if (start_dl) begin
      exp_q   <= '0;
      bc_q    <= '0;
      err_q   <= 1'b0;
      low_q   <= '0;
      valid_q <= 1'b0;
      pad_q   <= 1'b0;
    end else begin
      if (byte_hit) begin
        exp_q <= exp_q + A_ONE;
        bc_q  <= bc_q + A_ONE;
        if (!dl_addr[0]) low_q <= dl_data;
      end
      if (byte_bad) err_q <= 1'b1;
      // A byte may still land on the cycle dl_active falls; include it in the parity
      if (enter_flush) pad_q <= bc_q[0] ^ byte_hit;
      if (pad_push)    pad_q <= 1'b0;
      if (set_done)    valid_q <= (bc_q >= A_TWO) && !err_q;
    end
  end

  // Occupancy next value; includes the word currently presented on the write port
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
    else if (!push && pop) cnt_d = cnt_q - CNT_ONE;
  end

  // FIFO storage (contents are don't-care while empty, so no reset)
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= push_addr;
      fifo_data_q[wr_ptr_q] <= push_data;
    end
  end

  // FIFO pointers, stall flag and SDRAM write request
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      dl_wait_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      dl_wait_q <= (cnt_d >= WAIT_LVL);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_next;
      // Head stays in the FIFO until accepted, so the follow-on word sits at rd_next
      if (pop) begin
        if (cnt_q > CNT_ONE) begin
          mem_we_q   <= 1'b1;
          mem_addr_q <= fifo_addr_q[rd_next];
          mem_din_q  <= fifo_data_q[rd_next];
        end else begin
          mem_we_q <= 1'b0;
        end
      end else if (!mem_we_q && (cnt_q != '0)) begin
        mem_we_q   <= 1'b1;
        mem_addr_q <= fifo_addr_q[rd_ptr_q];
        mem_din_q  <= fifo_data_q[rd_ptr_q];
      end
    end
  end

  assign dl_wait     = dl_wait_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign mem_we      = mem_we_q;
  assign image_valid = valid_q;
  assign byte_count  = bc_q;
  assign error       = err_q;

endmodule

// File: tb/tb_bg_image_loader.sv
// Scoreboard bench for bg_image_loader: stimulus queues the expected SDRAM
// writes, independent monitors pop and compare them as writes are accepted.
module tb_bg_image_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        dl_active, dl_active2;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        mem_ready;

  logic        dl_wait, mem_we, image_valid, error;
  logic [24:0] mem_addr, byte_count;
  logic [15:0] mem_din;

  logic        dl_wait2, mem_we2, image_valid2, error2;
  logic [24:0] mem_addr2, byte_count2;
  logic [15:0] mem_din2;

  typedef struct packed {
    logic [24:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t exp1[$];
  wr_t exp2[$];

  int errors = 0;
  int checks = 0;

  always #5 clk_sys = ~clk_sys;

  bg_image_loader dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .dl_active   (dl_active),
    .dl_wr       (dl_wr),
    .dl_addr     (dl_addr),
    .dl_data     (dl_data),
    .dl_wait     (dl_wait),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_we      (mem_we),
    .mem_ready   (mem_ready),
    .image_valid (image_valid),
    .byte_count  (byte_count),
    .error       (error)
  );

  bg_image_loader #(.MAX_BYTES(4)) dut_small (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .dl_active   (dl_active2),
    .dl_wr       (dl_wr),
    .dl_addr     (dl_addr),
    .dl_data     (dl_data),
    .dl_wait     (dl_wait2),
    .mem_addr    (mem_addr2),
    .mem_din     (mem_din2),
    .mem_we      (mem_we2),
    .mem_ready   (mem_ready),
    .image_valid (image_valid2),
    .byte_count  (byte_count2),
    .error       (error2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d);
    dl_wr   = 1'b1;
    dl_addr = a;
    dl_data = d;
    tick();
    dl_wr   = 1'b0;
  endtask

  task automatic start_dl(input bit which);
    if (which) dl_active2 = 1'b1;
    else       dl_active  = 1'b1;
    tick();
  endtask

  task automatic finish_dl(input bit which, input logic exp_valid, input logic [24:0] exp_bc,
                           input logic exp_err, input string tag);
    int n;
    if (which) dl_active2 = 1'b0;
    else       dl_active  = 1'b0;
    dl_wr = 1'b0;
    n = 0;
    while (((which ? exp2.size() : exp1.size()) != 0) && (n < 300)) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, 32'(which ? exp2.size() : exp1.size()), 32'd0);
    repeat (6) tick();
    if (which) begin
      check({tag, "_valid"}, 32'(image_valid2), 32'(exp_valid));
      check({tag, "_count"}, 32'(byte_count2), 32'(exp_bc));
      check({tag, "_error"}, 32'(error2), 32'(exp_err));
      check({tag, "_we_idle"}, 32'(mem_we2), 32'd0);
    end else begin
      check({tag, "_valid"}, 32'(image_valid), 32'(exp_valid));
      check({tag, "_count"}, 32'(byte_count), 32'(exp_bc));
      check({tag, "_error"}, 32'(error), 32'(exp_err));
      check({tag, "_we_idle"}, 32'(mem_we), 32'd0);
      check({tag, "_wait_idle"}, 32'(dl_wait), 32'd0);
    end
  endtask

  function automatic logic [7:0] sd(input int i);
    return 8'(i * 7 + 3);
  endfunction

  // Monitor for the main instance: write ordering plus request stability
  initial begin
    logic        pend;
    logic [24:0] pa;
    logic [15:0] pd;
    wr_t         e;
    pend = 1'b0;
    pa   = '0;
    pd   = '0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("hold_we", 32'(mem_we), 32'd1);
          check("hold_addr", 32'(mem_addr), 32'(pa));
          check("hold_data", 32'(mem_din), 32'(pd));
        end
        if (mem_we && mem_ready) begin
          if (exp1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write", mem_addr, mem_din);
          end else begin
            e = exp1.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(e.a));
            check("wr_data", 32'(mem_din), 32'(e.d));
          end
        end
        pend = mem_we && !mem_ready;
        pa   = mem_addr;
        pd   = mem_din;
      end
    end
  end

  // Monitor for the MAX_BYTES=4 instance
  initial begin
    wr_t e;
    forever begin
      @(negedge clk_sys);
      if (reset_n && mem_we2 && mem_ready) begin
        if (exp2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write_small: got addr=%0h data=%0h, required no write", mem_addr2, mem_din2);
        end else begin
          e = exp2.pop_front();
          check("wr_addr_small", 32'(mem_addr2), 32'(e.a));
          check("wr_data_small", 32'(mem_din2), 32'(e.d));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  idx;
    bit  wprev, wcur;

    reset_n    = 1'b0;
    dl_active  = 1'b0;
    dl_active2 = 1'b0;
    dl_wr      = 1'b0;
    dl_addr    = '0;
    dl_data    = '0;
    mem_ready  = 1'b1;
    repeat (3) tick();

    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_dl_wait", 32'(dl_wait), 32'd0);
    check("rst_valid", 32'(image_valid), 32'd0);
    check("rst_count", 32'(byte_count), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_din", 32'(mem_din), 32'd0);
    reset_n = 1'b1;
    tick();

    // Four bytes, plus two-cycle latency from second strobe to mem_we
    start_dl(0);
    exp1.push_back('{a: 25'h0, d: 16'h2211});
    exp1.push_back('{a: 25'h2, d: 16'h4433});
    send(25'd0, 8'h11);
    send(25'd1, 8'h22);
    check("latency_1cyc", 32'(mem_we), 32'd0);
    tick();
    check("latency_2cyc", 32'(mem_we), 32'd1);
    send(25'd2, 8'h33);
    send(25'd3, 8'h44);
    finish_dl(0, 1'b1, 25'd4, 1'b0, "four");

    // Odd byte count: trailing byte padded with zero high byte
    start_dl(0);
    exp1.push_back('{a: 25'h0, d: 16'hBBAA});
    exp1.push_back('{a: 25'h2, d: 16'h00CC});
    send(25'd0, 8'hAA);
    send(25'd1, 8'hBB);
    send(25'd2, 8'hCC);
    finish_dl(0, 1'b1, 25'd3, 1'b0, "odd");

    // Back-pressure: SDRAM stalled for 20 cycles, source honours dl_wait one cycle late
    mem_ready = 1'b0;
    start_dl(0);
    for (int k = 0; k < 16; k++)
      exp1.push_back('{a: 25'(2 * k), d: {sd(2 * k + 1), sd(2 * k)}});
    idx   = 0;
    wprev = 1'b0;
    for (int cyc = 0; (cyc < 400) && (idx < 32); cyc++) begin
      if (cyc == 19) begin
        check("stall_dl_wait", 32'(dl_wait), 32'd1);
        check("stall_bytes_sent", 32'(idx), 32'd7);
      end
      if (cyc == 20) mem_ready = 1'b1;
      wcur = dl_wait;
      if (!wprev) begin
        dl_wr   = 1'b1;
        dl_addr = 25'(idx);
        dl_data = sd(idx);
        idx++;
      end else begin
        dl_wr = 1'b0;
      end
      wprev = wcur;
      tick();
    end
    dl_wr     = 1'b0;
    mem_ready = 1'b1;
    check("stream_bytes_sent", 32'(idx), 32'd32);
    finish_dl(0, 1'b1, 25'd32, 1'b0, "stall");

    // Address skip: second byte dropped, first padded out
    start_dl(0);
    exp1.push_back('{a: 25'h0, d: 16'h005A});
    send(25'd0, 8'h5A);
    send(25'd2, 8'h77);
    finish_dl(0, 1'b0, 25'd1, 1'b1, "skip");

    // Asynchronous reset while a write is pending
    mem_ready = 1'b0;
    start_dl(0);
    for (int i = 0; i < 6; i++) send(25'(i), 8'(8'h80 + i));
    check("pre_reset_we", 32'(mem_we), 32'd1);
    check("pre_reset_count", 32'(byte_count), 32'd6);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_we", 32'(mem_we), 32'd0);
    check("async_rst_valid", 32'(image_valid), 32'd0);
    check("async_rst_count", 32'(byte_count), 32'd0);
    check("async_rst_wait", 32'(dl_wait), 32'd0);
    dl_active = 1'b0;
    tick();
    reset_n   = 1'b1;
    mem_ready = 1'b1;
    tick();
    start_dl(0);
    exp1.push_back('{a: 25'h0, d: 16'h0201});
    exp1.push_back('{a: 25'h2, d: 16'h0403});
    send(25'd0, 8'h01);
    send(25'd1, 8'h02);
    send(25'd2, 8'h03);
    send(25'd3, 8'h04);
    finish_dl(0, 1'b1, 25'd4, 1'b0, "post_reset");

    // Size limit on the MAX_BYTES=4 instance: bytes 4 and 5 dropped
    start_dl(1);
    exp2.push_back('{a: 25'h0, d: 16'hB2A1});
    exp2.push_back('{a: 25'h2, d: 16'hD4C3});
    send(25'd0, 8'hA1);
    send(25'd1, 8'hB2);
    send(25'd2, 8'hC3);
    send(25'd3, 8'hD4);
    send(25'd4, 8'hE5);
    send(25'd5, 8'hF6);
    finish_dl(1, 1'b0, 25'd4, 1'b1, "max");

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
